// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with single-outstanding imem port and IF/ID register
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc, pc_d;
    logic [XLEN-1:0] hold_pc, hold_instr;
    logic [XLEN-1:0] redir_target;
    logic            load_mem, load_hold, capture;
    logic            fault_q, fault_set;

    assign redir_target = redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault_set = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign fault_set = 1'b0;
    assign fault_q   = 1'b0;
`endif

    assign fetch_fault = fault_q;
    assign imem_req    = rst_n && (state_q == ISSUE) && !fault_q;
    assign imem_addr   = fetch_pc;

    always_comb begin
        state_d   = state_q;
        pc_d      = fetch_pc;
        load_mem  = 1'b0;
        load_hold = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ISSUE: if (imem_gnt) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (!ifid_valid || !stall) begin
                        load_mem = 1'b1;
                        pc_d     = fetch_pc + XLEN'(4);
                        state_d  = ISSUE;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    load_hold = 1'b1;
                    pc_d      = fetch_pc + XLEN'(4);
                    state_d   = ISSUE;
                end
            end
            DRAIN: if (imem_rvalid) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase

        // A redirect beats stall and any pending delivery; an outstanding
        // request must still be drained before the new address is issued.
        if (redirect_valid) begin
            load_mem  = 1'b0;
            load_hold = 1'b0;
            capture   = 1'b0;
            pc_d      = redir_target;
            case (state_q)
                ISSUE:   state_d = imem_gnt ? DRAIN : ISSUE;
                WAIT:    state_d = imem_rvalid ? ISSUE : DRAIN;
                HOLD:    state_d = ISSUE;
                default: ;
            endcase
        end

        if (fault_q || fault_set) begin
            load_mem  = 1'b0;
            load_hold = 1'b0;
            capture   = 1'b0;
            pc_d      = fetch_pc;
            state_d   = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ISSUE;
            fetch_pc   <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
        end else begin
            state_q  <= state_d;
            fetch_pc <= pc_d;

            if (capture) begin
                hold_pc    <= fetch_pc;
                hold_instr <= imem_rdata;
            end else if (redirect_valid) begin
                hold_pc    <= '0;
                hold_instr <= '0;
            end

            if (redirect_valid || fault_q || fault_set) begin
                ifid_valid <= 1'b0;
            end else if (load_mem) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= fetch_pc;
                ifid_instr <= imem_rdata;
            end else if (load_hold) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= hold_pc;
                ifid_instr <= hold_instr;
            end else if (!stall) begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory and program-order reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        fetch_fault;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Program-order model: exp_pc is the next instruction decode must see.
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          deliveries = 0;

    // Memory model: one pending response with a countdown.
    bit          pending = 1'b0;
    bit          gnt_now = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cnt = 0;
    int          gnt_pct = 100;
    int          min_lat = 1;
    int          max_lat = 1;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        gnt_now     = 1'b0;
        if (pending) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pending     = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (imem_req && !pending && !imem_rvalid && (int'($urandom_range(99)) < gnt_pct)) begin
            imem_gnt = 1'b1;
            gnt_now  = 1'b1;
            pending  = 1'b1;
            paddr    = imem_addr;
            cnt      = int'($urandom_range(max_lat, min_lat)) - 1;
        end
    endtask

    task automatic step();
        logic applied_stall;
        logic applied_redir;
        @(negedge clk);
        applied_stall = stall;
        applied_redir = redirect_valid;
        if (applied_redir) begin
            chk1("redirect_flush", ifid_valid, 1'b0);
        end else if (prev_valid && applied_stall) begin
            chk1("stall_hold_valid", ifid_valid, 1'b1);
            chk("stall_hold_pc", ifid_pc, prev_pc);
            chk("stall_hold_instr", ifid_instr, prev_instr);
        end
        if (ifid_valid && !(prev_valid && applied_stall)) begin
            chk("deliver_pc", ifid_pc, exp_pc);
            chk("deliver_instr", ifid_instr, mem_word(exp_pc));
            last_pc = ifid_pc;
            exp_pc  = exp_pc + 32'd4;
            deliveries++;
        end
        if (imem_req) chk("req_addr", imem_addr, exp_pc);
        prev_valid     = ifid_valid;
        prev_pc        = ifid_pc;
        prev_instr     = ifid_instr;
        redirect_valid = 1'b0;
        drive_mem();
    endtask

    task automatic redirect(logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_pc         = t & ~32'h3;
    endtask

    task automatic wait_delivery(string tag, logic [31:0] pc);
        int d0;
        d0 = deliveries;
        for (int k = 0; k < 60 && deliveries == d0; k++) step();
        chk1({tag, "_progress"}, deliveries != d0, 1'b1);
        chk({tag, "_pc"}, last_pc, pc);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        pending        = 1'b0;
        #1;
        chk1("reset_ifid_valid", ifid_valid, 1'b0);
        chk("reset_ifid_pc", ifid_pc, 32'h0);
        chk("reset_ifid_instr", ifid_instr, 32'h0);
        chk1("reset_fault", fetch_fault, 1'b0);
        repeat (2) @(negedge clk);
        chk1("reset_req_low", imem_req, 1'b0);
        rst_n      = 1'b1;
        exp_pc     = 32'h0;
        prev_valid = 1'b0;
        #1;
        chk1("release_req", imem_req, 1'b1);
        chk("release_addr", imem_addr, 32'h0);
        drive_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        gnt_pct = 100; min_lat = 1; max_lat = 1;
        do_reset();

        // Immediate grant, 1-cycle memory: one instruction every other cycle.
        for (int i = 1; i <= 6; i++) begin
            step();
            chk1("cadence_valid", ifid_valid, (i % 2) == 0);
        end
        chk("cadence_count", 32'(deliveries), 32'd3);
        chk("cadence_last_pc", last_pc, 32'h8);

        // Stall while a response arrives: it parks in the hold buffer.
        stall = 1'b1;
        repeat (5) step();
        chk1("hold_req_low", imem_req, 1'b0);
        chk1("hold_ifid_valid", ifid_valid, 1'b1);
        chk("hold_ifid_pc", ifid_pc, 32'h8);
        stall = 1'b0;
        step();
        chk("unstall_pc", ifid_pc, 32'hC);
        chk1("unstall_req", imem_req, 1'b1);

        // Redirect while waiting on a slow response.
        min_lat = 3; max_lat = 3;
        for (int k = 0; k < 10 && !gnt_now; k++) step();
        chk1("gnt_seen", gnt_now, 1'b1);
        step();
        redirect(32'h100);
        wait_delivery("redirect_wait", 32'h100);

        // Redirect with stall high and a full hold buffer.
        min_lat = 1; max_lat = 1;
        stall = 1'b1;
        repeat (4) step();
        redirect(32'h200);
        step();
        chk1("redir_stall_req", imem_req, 1'b1);
        chk("redir_stall_addr", imem_addr, 32'h200);
        stall = 1'b0;
        wait_delivery("redirect_stall", 32'h200);

        // Address wrap at the top of memory.
        redirect(32'hFFFF_FFFC);
        wait_delivery("wrap_top", 32'hFFFF_FFFC);
        wait_delivery("wrap_zero", 32'h0);

        // Misaligned redirect.
        redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (4) step();
        chk1("misalign_fault", fetch_fault, 1'b1);
        chk1("misalign_req", imem_req, 1'b0);
        chk1("misalign_valid", ifid_valid, 1'b0);
        do_reset();
`else
        wait_delivery("misalign_aligned", 32'h100);
        chk1("misalign_no_fault", fetch_fault, 1'b0);
`endif

        // Reset in the middle of a transaction.
        step();
        do_reset();

        // Randomized traffic: variable grant/latency, stalls and redirects.
        gnt_pct = 60; min_lat = 1; max_lat = 4;
        d0 = deliveries;
        for (int i = 0; i < 800; i++) begin
            stall = (int'($urandom_range(99)) < 30);
            if (int'($urandom_range(99)) < 5) begin
                if ($urandom_range(3) == 0) redirect(32'hFFFF_FFF0);
                else redirect($urandom & 32'h0000_FFFC);
            end
            step();
        end
        stall = 1'b0;
        chk1("random_progress", (deliveries - d0) > 20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the fetch PC and issues single-outstanding requests to instruction memory.
- Delivers one {pc, instr, valid} bundle per accepted instruction into the IF/ID register consumed by decode.
- Holds its output while the load-use hazard stall is asserted.
- Squashes in-flight and buffered work on a control-flow redirect from EX.

Parameters:
XLEN, 32, address/data width.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard stall; hold IF/ID contents, accept nothing new.
redirect_valid  in  1  EX branch/JALR taken; 1-cycle pulse.
redirect_pc  in  XLEN  redirect target.
imem_req  out  1  request valid.
imem_addr  out  XLEN  request address (=fetch_pc).
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  response data valid (≥1 cycle after gnt).
imem_rdata  in  XLEN  instruction word.
ifid_valid  out  1  IF/ID holds a live instruction.
ifid_pc  out  XLEN  PC of ifid_instr.
ifid_instr  out  XLEN  instruction word.
fetch_fault  out  1  misaligned redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset is asynchronous, active-low: state=ISSUE, fetch_pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=0 (NOP 32'h0000_0013 is not used; zero), hold buffer empty, fetch_fault=0. imem_req=0 while rst_n low; it asserts in the first cycle after release.
- States: ISSUE, WAIT, HOLD, DRAIN. At most one memory transaction is outstanding.
- ISSUE: imem_req=1, imem_addr=fetch_pc. On imem_gnt go to WAIT. imem_addr may change before gnt only due to redirect.
- WAIT: imem_req=0. On imem_rvalid:
  - IF/ID free (ifid_valid==0 or stall==0): load ifid={fetch_pc, rdata, 1}; fetch_pc+=4; go to ISSUE.
  - Otherwise: capture {fetch_pc, rdata} in the hold buffer and go to HOLD.
- HOLD: imem_req=0. When stall==0, move the buffer into IF/ID (valid=1); fetch_pc+=4; go to ISSUE.
- IF/ID consumption: if stall==0 and nothing new is loaded this cycle, ifid_valid<=0. If stall==1, all ifid_* hold.
- fetch_pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Fetch-to-IF/ID latency with a 1-cycle memory: ISSUE+gnt at cycle n, rvalid at n+1, ifid_valid visible at n+2. Steady-state throughput is one instruction per 2 cycles.
- Redirect has the highest priority and overrides stall. In the cycle redirect_valid=1: ifid_valid<=0, hold buffer cleared, fetch_pc<=redirect_pc. Next state per current state:
  - ISSUE without gnt -> ISSUE, with the new address from the next cycle.
  - ISSUE with gnt same cycle -> DRAIN.
  - WAIT without rvalid -> DRAIN.
  - WAIT with rvalid same cycle -> response discarded, ISSUE.
  - HOLD -> ISSUE.
  - DRAIN -> stays DRAIN.
- DRAIN: imem_req=0. The next imem_rvalid is discarded, then go to ISSUE. A redirect arriving in DRAIN only updates fetch_pc.
- imem_rvalid outside WAIT/DRAIN is a protocol error and is ignored.
- Reset asserted mid-transaction: immediate return to reset values. Memory is assumed reset concurrently.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset). The unit enters HOLD-like idle with imem_req=0 and ifid_valid=0, and stops fetching. Aligned redirects behave normally.
- Undefined: fetch_fault tied 0; redirect_pc[1:0] forced to 2'b00 before loading fetch_pc.

Test Plan:
- Reset release, RESET_PC=0, memory gnt immediate, rvalid next cycle returning 0x11,0x22,0x33 -> imem_addr 0,4,8; ifid (pc,instr) = (0,0x11),(4,0x22),(8,0x33), each valid one cycle, no gaps beyond the 2-cycle cadence.
- stall=1 for 5 cycles while ifid holds (4,0x22) and rvalid delivers 0x33 -> ifid holds (4,0x22) all 5 cycles, state HOLD, imem_req=0. Stall drop -> ifid=(8,0x33) next cycle, then req addr 12.
- redirect_valid=1, redirect_pc=0x100 in WAIT (rvalid 2 cycles later with 0xDEAD) -> 0xDEAD never appears on ifid, ifid_valid=0, next imem_addr=0x100.
- redirect coincident with stall=1 and a full hold buffer -> ifid_valid=0, buffer dropped, fetch from redirect_pc next cycle.
- fetch_pc=32'hFFFF_FFFC fetched -> next imem_addr=0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> fetch_fault=1, imem_req stays 0. Without it -> next imem_addr=0x100.
